// File: rtl/stream_pipe_fifo.sv
// stream_pipe_fifo
//   Valid/ready stream block: accepted beats ({mode, up_data}) travel through
//   a STAGES-deep register pipeline with collapsing bubbles, are transformed
//   according to their carried mode as they enter a 2**A_WIDTH-entry output
//   FIFO, and are presented downstream from the FIFO head.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset (dominates flush)
//   flush        synchronous clear of pipeline and FIFO, beat_count kept
//   mode[1:0]    per-beat transform: 00 pass, 01 invert, 10 +1, 11 rotl 1
//   up_data      upstream payload
//   up_valid     upstream beat present
//   up_ready     block accepts a beat this cycle
//   down_data    oldest FIFO entry
//   down_valid   FIFO not empty
//   down_ready   downstream accepts the beat
//   fill_level   FIFO occupancy
//   almost_full  fill_level >= AF_LEVEL
//   beat_count   saturating count of downstream transfers

module stream_pipe_fifo #(
    parameter int D_WIDTH  = 6,
    parameter int A_WIDTH  = 2,
    parameter int STAGES   = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [1:0]         mode,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [A_WIDTH:0]   fill_level,
    output logic               almost_full,
    output logic [15:0]        beat_count
);

    localparam int PW    = D_WIDTH + 2;
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam int LAST  = STAGES - 1;
    localparam logic [A_WIDTH:0] DEPTH_L = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH:0] AF_L    = (A_WIDTH + 1)'(AF_LEVEL);

    logic [STAGES-1:0]  stg_v;
    logic [STAGES-1:0]  stg_load;
    logic [PW-1:0]      stg_d [STAGES];
    logic               take;
    logic               up_fire;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [1:0]         last_mode;
    logic [D_WIDTH-1:0] last_data;
    logic [D_WIDTH-1:0] wr_data;
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;

    // A full FIFO refuses the write even when a read frees a slot this cycle;
    // this keeps the ready path from depending on down_ready.
    assign fifo_wr = !flush && stg_v[LAST] && (fill_level != DEPTH_L);
    assign fifo_rd = !flush && (fill_level != '0) && down_ready;

    // Walk from the FIFO end back to stage 0: a stage may load when it is
    // empty or its content is being taken by the next stage in this cycle.
    always_comb begin
        stg_load = '0;
        take     = fifo_wr;
        for (int i = STAGES - 1; i >= 0; i--) begin
            take        = !stg_v[i] || take;
            stg_load[i] = take;
        end
    end

    assign up_ready = !rst && !flush && stg_load[0];
    assign up_fire  = up_valid && up_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stg_v <= '0;
        end else begin
            if (stg_load[0]) stg_v[0] <= up_fire;
            for (int i = 1; i < STAGES; i++) begin
                if (stg_load[i]) stg_v[i] <= stg_v[i-1];
            end
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (stg_load[0] && up_fire) stg_d[0] <= {mode, up_data};
        for (int i = 1; i < STAGES; i++) begin
            if (stg_load[i] && stg_v[i-1]) stg_d[i] <= stg_d[i-1];
        end
    end

    assign last_mode = stg_d[LAST][PW-1 -: 2];
    assign last_data = stg_d[LAST][D_WIDTH-1:0];

    always_comb begin
        wr_data = last_data;
        case (last_mode)
            2'b01:   wr_data = ~last_data;
            2'b10:   wr_data = last_data + D_WIDTH'(1);
            2'b11:   wr_data = {last_data[D_WIDTH-2:0], last_data[D_WIDTH-1]};
            default: wr_data = last_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + A_WIDTH'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + A_WIDTH'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   fill_level <= fill_level + (A_WIDTH + 1)'(1);
                2'b01:   fill_level <= fill_level - (A_WIDTH + 1)'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
        end else if (fifo_rd && (beat_count != 16'hFFFF)) begin
            beat_count <= beat_count + 16'd1;
        end
    end

    assign down_valid  = (fill_level != '0);
    assign down_data   = mem[rd_ptr];
    assign almost_full = (fill_level >= AF_L);

endmodule

// File: tb/tb_stream_pipe_fifo.sv
module tb_stream_pipe_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] mode;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready;
    logic [2:0] fill_level;
    logic       almost_full;
    logic [15:0] beat_count;

    int checks   = 0;
    int failures = 0;
    int acc, target, base, bc, pct;
    logic [5:0] got[$];
    logic [5:0] q[$];

    typedef struct {
        logic [1:0] m;
        logic [5:0] d;
        logic [5:0] e;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    stream_pipe_fifo dut (
        .clk(clk), .rst(rst), .flush(flush), .mode(mode),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
        .fill_level(fill_level), .almost_full(almost_full), .beat_count(beat_count)
    );

    // Transform written as plain arithmetic on the 6-bit value.
    function automatic logic [5:0] ref_xf(input logic [1:0] m, input logic [5:0] d);
        int v;
        v = int'(d);
        case (m)
            2'd1:    v = 63 - v;
            2'd2:    v = (v + 1) % 64;
            2'd3:    v = (v * 2) % 64 + v / 32;
            default: v = v;
        endcase
        return 6'(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of directed streaming: records accepted/delivered beats.
    task automatic run_cycle();
        logic uf, df;
        logic [5:0] dd;
        #1;
        uf = up_valid && up_ready;
        df = down_valid && down_ready && !flush && !rst;
        dd = down_data;
        step();
        if (df) begin
            got.push_back(dd);
            bc++;
        end
        if (uf) begin
            acc++;
            up_data = 6'(base + acc);
            if (acc == target) up_valid = 1'b0;
        end
    endtask

    // Single beat into an empty block; checks latency and one-cycle output.
    task automatic send_single(input logic [1:0] m, input logic [5:0] d, input logic [5:0] e);
        down_ready = 1'b1;
        mode       = m;
        up_data    = d;
        up_valid   = 1'b1;
        #1;
        check("single_up_ready", int'(up_ready), 1);
        step();
        up_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("latency_early", int'(down_valid), 0);
            step();
        end
        check("latency_valid", int'(down_valid), 1);
        check("xform_data", int'(down_data), int'(e));
        step();
        bc++;
        check("single_one_cycle", int'(down_valid), 0);
        check("single_beat_count", int'(beat_count), bc);
    endtask

    // Random cycle checked against a queue model of in-flight beats.
    task automatic sb_cycle();
        logic uf, df, fl;
        logic [5:0] exp_d;
        #1;
        check("dv_vs_fill", int'(down_valid), int'(fill_level != 0));
        check("af_vs_fill", int'(almost_full), int'(fill_level >= 3));
        check("inflight_max", int'(q.size() <= 8), 1);
        check("fill_le_inflight", int'(int'(fill_level) <= q.size()), 1);
        if (q.size() == 8) check("full_no_ready", int'(up_ready), 0);
        if (q.size() == 0 && !flush) check("empty_ready", int'(up_ready), 1);
        uf = up_valid && up_ready;
        df = down_valid && down_ready && !flush;
        fl = flush;
        if (df) begin
            check("sb_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                exp_d = q.pop_front();
                check("sb_data", int'(down_data), int'(exp_d));
            end
            bc++;
        end
        if (uf) q.push_back(ref_xf(mode, up_data));
        if (fl) q.delete();
        step();
        if (uf) up_valid = 1'b0;
        check("sb_beat_count", int'(beat_count), (bc > 65535) ? 65535 : bc);
        if (fl) check("flush_fill", int'(fill_level), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b00, 6'h15, 6'h15};
        vecs[1] = '{2'b01, 6'h3F, 6'h00};
        vecs[2] = '{2'b10, 6'h3F, 6'h00};
        vecs[3] = '{2'b11, 6'h3F, 6'h3F};
        vecs[4] = '{2'b11, 6'h21, 6'h03};
        vecs[5] = '{2'b01, 6'h15, 6'h2A};
        vecs[6] = '{2'b10, 6'h15, 6'h16};
        vecs[7] = '{2'b11, 6'h15, 6'h2A};
        vecs[8] = '{2'b10, 6'h00, 6'h01};
        vecs[9] = '{2'b00, 6'h3F, 6'h3F};

        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
        mode = 2'b00; up_data = 6'h00;
        bc = 0; acc = 0; target = 0; base = 0; pct = 0;

        // Reset state
        #1;
        check("rst_up_ready", int'(up_ready), 0);
        step();
        check("rst_fill", int'(fill_level), 0);
        check("rst_down_valid", int'(down_valid), 0);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_beat_count", int'(beat_count), 0);
        check("rst_up_ready_held", int'(up_ready), 0);
        rst = 1'b0;
        #1;
        check("idle_up_ready", int'(up_ready), 1);

        // Transform / latency table
        for (int i = 0; i < 10; i++) send_single(vecs[i].m, vecs[i].d, vecs[i].e);

        // Backpressure: 12 beats offered with down_ready low
        down_ready = 1'b0; acc = 0; target = 12; base = 0;
        mode = 2'b00; up_data = 6'h00; up_valid = 1'b1; got.delete();
        for (int c = 0; c < 20; c++) begin
            run_cycle();
            if (fill_level == 3) check("af_at_3", int'(almost_full), 1);
            if (fill_level == 2) check("af_at_2", int'(almost_full), 0);
        end
        check("bp_accepted", acc, 8);
        check("bp_fill", int'(fill_level), 4);
        check("bp_almost_full", int'(almost_full), 1);
        check("bp_up_ready", int'(up_ready), 0);
        check("bp_head", int'(down_data), 0);
        check("bp_no_delivery", got.size(), 0);

        // Full FIFO: read happens, write refused in that same cycle
        down_ready = 1'b1;
        run_cycle();
        check("full_rd_fill", int'(fill_level), 3);
        check("full_rd_no_accept", acc, 8);
        down_ready = 1'b0;
        run_cycle();
        check("full_wr_fill", int'(fill_level), 4);
        check("full_wr_accept", acc, 9);
        check("full_wr_head", int'(down_data), 1);

        down_ready = 1'b1;
        for (int c = 0; c < 60 && got.size() < 12; c++) run_cycle();
        check("bp_delivered", got.size(), 12);
        for (int i = 0; i < got.size(); i++) check("bp_order", int'(got[i]), i);
        check("bp_drained", int'(fill_level), 0);
        check("bp_beat_count", int'(beat_count), bc);

        // Flush with 2 in the FIFO and 3 in the pipeline
        down_ready = 1'b0; acc = 0; target = 5; base = 6'h30;
        mode = 2'b00; up_data = 6'h30; up_valid = 1'b1; got.delete();
        for (int c = 0; c < 20 && fill_level != 2; c++) run_cycle();
        check("pre_flush_fill", int'(fill_level), 2);
        check("pre_flush_accepted", acc, 5);
        flush = 1'b1;
        #1;
        check("flush_up_ready", int'(up_ready), 0);
        step();
        flush = 1'b0;
        check("post_flush_fill", int'(fill_level), 0);
        check("post_flush_valid", int'(down_valid), 0);
        check("post_flush_beat_count", int'(beat_count), bc);
        down_ready = 1'b1;
        for (int c = 0; c < 12; c++) run_cycle();
        check("flush_no_ghost", got.size(), 0);
        check("flush_beat_count_kept", int'(beat_count), bc);
        send_single(2'b10, 6'h07, 6'h08);

        // Reset mid-stream
        acc = 0; target = 6; base = 6'h10;
        mode = 2'b01; up_data = 6'h10; up_valid = 1'b1; down_ready = 1'b1; got.delete();
        for (int c = 0; c < 6; c++) run_cycle();
        check("mid_delivered", got.size(), 1);
        if (got.size() > 0) check("mid_first", int'(got[0]), 6'h2F);
        rst = 1'b1;
        #1;
        check("mid_rst_up_ready", int'(up_ready), 0);
        step();
        rst = 1'b0;
        bc = 0;
        check("mid_rst_fill", int'(fill_level), 0);
        check("mid_rst_valid", int'(down_valid), 0);
        check("mid_rst_af", int'(almost_full), 0);
        check("mid_rst_beat_count", int'(beat_count), 0);
        send_single(2'b11, 6'h21, 6'h03);

        // Random traffic against the queue model
        q.delete();
        up_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 250) % 4)
                0:       pct = 15;
                1:       pct = 50;
                2:       pct = 90;
                default: pct = 100;
            endcase
            if (!up_valid) begin
                up_valid = ($urandom_range(0, 3) != 0);
                mode     = 2'($urandom_range(0, 3));
                up_data  = 6'($urandom_range(0, 63));
            end
            down_ready = ($urandom_range(0, 99) < pct);
            flush      = ($urandom_range(0, 149) == 0);
            sb_cycle();
        end
        up_valid = 1'b0; flush = 1'b0; down_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) sb_cycle();
        check("drain_model_empty", q.size(), 0);
        check("drain_fill", int'(fill_level), 0);
        check("drain_valid", int'(down_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
